pulse_decoder_2x4: RTL and testbench

Sequential receive-side counterpart of the 4-to-2 priority encoder. Accepts an encoded index `{code, v}` over a valid/ready handshake, decodes it to a one-hot line, and drives that line for a programmable number of cycles, followed by a programmable guard gap. Sits downstream of the encoder and turns a registered grant index back into a timed one-hot select or strobe.

---
 rtl/enc_pkg.sv | 18 +
 rtl/onehot_dec_2x4.sv | 21 ++
 rtl/pulse_decoder_2x4.sv | 119 +++++++++++
 tb/tb_pulse_decoder_2x4.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/enc_pkg.sv
// Shared definitions for the encoder/decoder pair: decoder FSM states,
// one-hot line constants and the counter width.
package enc_pkg;

    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } dec_state_t;

    localparam logic [3:0] OH_0 = 4'b0001;
    localparam logic [3:0] OH_1 = 4'b0010;
    localparam logic [3:0] OH_2 = 4'b0100;
    localparam logic [3:0] OH_3 = 4'b1000;

endpackage

// File: rtl/onehot_dec_2x4.sv
// Purely combinational 2-to-4 one-hot decoder.
module onehot_dec_2x4
    import enc_pkg::*;
(
    input  logic [1:0] code_i,
    output logic [3:0] onehot_o
);

    // Map the 2-bit index to its one-hot line.
    always_comb begin
        onehot_o = OH_0;
        unique case (code_i)
            2'd0: onehot_o = OH_0;
            2'd1: onehot_o = OH_1;
            2'd2: onehot_o = OH_2;
            2'd3: onehot_o = OH_3;
            default: onehot_o = OH_0;
        endcase
    end

endmodule

// File: rtl/pulse_decoder_2x4.sv
// Accepts an encoded index {code, v} over valid/ready, drives the decoded
// one-hot line for PULSE_LEN cycles, then enforces GAP_LEN idle cycles.
module pulse_decoder_2x4
    import enc_pkg::*;
#(
    parameter int unsigned PULSE_LEN = 4,
    parameter int unsigned GAP_LEN   = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [1:0] code,
    input  logic       v,
    output logic [3:0] y,
    output logic       busy,
    output logic       done,
    output logic       none
);

    if (PULSE_LEN < 1 || PULSE_LEN > 255) begin : g_bad_pulse_len
        $error("PULSE_LEN must be in 1..255");
    end
    if (GAP_LEN > 255) begin : g_bad_gap_len
        $error("GAP_LEN must be in 0..255");
    end

    dec_state_t         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [3:0]         y_q, y_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               none_q, none_d;
    logic [3:0]         onehot;
    logic               accept;

    onehot_dec_2x4 u_onehot_dec (
        .code_i   (code),
        .onehot_o (onehot)
    );

    // Ready is combinational so a new code can be taken in the cycle the FSM reaches IDLE.
    assign in_ready = rst_n && (state_q == IDLE);
    assign accept   = in_valid && in_ready;

    // Next-state, counter and registered-output logic.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        y_d     = y_q;
        done_d  = 1'b0;
        none_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (v) begin
                        state_d = DRIVE;
                        y_d     = onehot;
                        cnt_d   = CNT_W'(PULSE_LEN - 1);
                    end else begin
                        none_d = 1'b1;
                    end
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    y_d    = 4'b0000;
                    done_d = 1'b1;
                    if (GAP_LEN > 0) begin
                        state_d = GAP;
                        cnt_d   = CNT_W'(GAP_LEN - 1);
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                y_d     = 4'b0000;
                cnt_d   = '0;
            end
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset aborts any pulse without a done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            y_q     <= 4'b0000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            none_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            y_q     <= y_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            none_q  <= none_d;
        end
    end

    assign y    = y_q;
    assign busy = busy_q;
    assign done = done_q;
    assign none = none_q;

endmodule

// File: tb/tb_pulse_decoder_2x4.sv
// Directed bench for pulse_decoder_2x4: default parameters plus the
// PULSE_LEN=1 / GAP_LEN=0 boundary instance.
module tb_pulse_decoder_2x4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance
    logic       a_rst_n = 1'b0, a_in_valid = 1'b0, a_v = 1'b0;
    logic [1:0] a_code = 2'd0;
    logic       a_in_ready, a_busy, a_done, a_none;
    logic [3:0] a_y;

    // Boundary-parameter instance
    logic       b_rst_n = 1'b0, b_in_valid = 1'b0, b_v = 1'b0;
    logic [1:0] b_code = 2'd0;
    logic       b_in_ready, b_busy, b_done, b_none;
    logic [3:0] b_y;

    pulse_decoder_2x4 u_dut_a (
        .clk      (clk),
        .rst_n    (a_rst_n),
        .in_valid (a_in_valid),
        .in_ready (a_in_ready),
        .code     (a_code),
        .v        (a_v),
        .y        (a_y),
        .busy     (a_busy),
        .done     (a_done),
        .none     (a_none)
    );

    pulse_decoder_2x4 #(
        .PULSE_LEN (1),
        .GAP_LEN   (0)
    ) u_dut_b (
        .clk      (clk),
        .rst_n    (b_rst_n),
        .in_valid (b_in_valid),
        .in_ready (b_in_ready),
        .code     (b_code),
        .v        (b_v),
        .y        (b_y),
        .busy     (b_busy),
        .done     (b_done),
        .none     (b_none)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; outputs are then stable for the new cycle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [3:0] exp_y;

        // Reset then idle
        tick();
        check_eq("rst_ready", {7'd0, a_in_ready}, 8'd0);
        tick();
        check_eq("rst_y", {4'd0, a_y}, 8'h00);
        check_eq("rst_busy", {7'd0, a_busy}, 8'd0);
        check_eq("rst_done", {7'd0, a_done}, 8'd0);
        check_eq("rst_none", {7'd0, a_none}, 8'd0);
        a_rst_n = 1'b1;
        #1;
        check_eq("post_rst_ready", {7'd0, a_in_ready}, 8'd1);
        tick();
        check_eq("idle_y", {4'd0, a_y}, 8'h00);
        check_eq("idle_busy", {7'd0, a_busy}, 8'd0);

        // Single decode, code=2
        a_code = 2'd2; a_v = 1'b1; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("single_y_%0d", i), {4'd0, a_y}, 8'h04);
            check_eq($sformatf("single_busy_%0d", i), {7'd0, a_busy}, 8'd1);
            check_eq($sformatf("single_ready_%0d", i), {7'd0, a_in_ready}, 8'd0);
            check_eq($sformatf("single_done_%0d", i), {7'd0, a_done}, 8'd0);
            tick();
        end
        check_eq("single_done", {7'd0, a_done}, 8'd1);
        check_eq("single_gap_y", {4'd0, a_y}, 8'h00);
        check_eq("single_gap_busy", {7'd0, a_busy}, 8'd1);
        check_eq("single_gap_ready", {7'd0, a_in_ready}, 8'd0);
        tick();
        check_eq("single_ready_back", {7'd0, a_in_ready}, 8'd1);
        check_eq("single_done_clr", {7'd0, a_done}, 8'd0);
        check_eq("single_busy_clr", {7'd0, a_busy}, 8'd0);

        // All codes back-to-back with in_valid held high
        a_in_valid = 1'b1; a_v = 1'b1;
        for (int c = 0; c < 4; c++) begin
            a_code = 2'(c);
            exp_y = 4'b0001 << c;
            check_eq($sformatf("all_ready_%0d", c), {7'd0, a_in_ready}, 8'd1);
            tick();
            for (int i = 0; i < 4; i++) begin
                check_eq($sformatf("all_y_%0d_%0d", c, i), {4'd0, a_y}, {4'd0, exp_y});
                tick();
            end
            check_eq($sformatf("all_done_%0d", c), {7'd0, a_done}, 8'd1);
            check_eq($sformatf("all_gap_y_%0d", c), {4'd0, a_y}, 8'h00);
            tick();
        end
        a_in_valid = 1'b0;
        check_eq("all_end_ready", {7'd0, a_in_ready}, 8'd1);

        // Empty code accepted three cycles running
        a_in_valid = 1'b1; a_v = 1'b0; a_code = 2'd3;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("empty_none_%0d", i), {7'd0, a_none}, 8'd1);
            check_eq($sformatf("empty_y_%0d", i), {4'd0, a_y}, 8'h00);
            check_eq($sformatf("empty_busy_%0d", i), {7'd0, a_busy}, 8'd0);
            check_eq($sformatf("empty_ready_%0d", i), {7'd0, a_in_ready}, 8'd1);
        end
        a_in_valid = 1'b0;
        tick();
        check_eq("empty_none_clr", {7'd0, a_none}, 8'd0);

        // Mid-pulse reset
        a_code = 2'd3; a_v = 1'b1; a_in_valid = 1'b1;
        tick();
        a_in_valid = 1'b0;
        check_eq("midrst_y1", {4'd0, a_y}, 8'h08);
        tick();
        check_eq("midrst_y2", {4'd0, a_y}, 8'h08);
        a_rst_n = 1'b0;
        #1;
        check_eq("midrst_ready_low", {7'd0, a_in_ready}, 8'd0);
        tick();
        check_eq("midrst_y_clr", {4'd0, a_y}, 8'h00);
        check_eq("midrst_done", {7'd0, a_done}, 8'd0);
        check_eq("midrst_busy", {7'd0, a_busy}, 8'd0);
        a_rst_n = 1'b1;
        #1;
        check_eq("midrst_ready_back", {7'd0, a_in_ready}, 8'd1);
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq($sformatf("midrst_no_done_%0d", i), {7'd0, a_done}, 8'd0);
            check_eq($sformatf("midrst_idle_y_%0d", i), {4'd0, a_y}, 8'h00);
        end

        // Boundary: PULSE_LEN=1, GAP_LEN=0
        tick();
        b_rst_n = 1'b1;
        #1;
        check_eq("b_ready", {7'd0, b_in_ready}, 8'd1);
        b_code = 2'd1; b_v = 1'b1; b_in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check_eq($sformatf("b_y_%0d", i), {4'd0, b_y}, 8'h02);
            check_eq($sformatf("b_busy_%0d", i), {7'd0, b_busy}, 8'd1);
            check_eq($sformatf("b_ready_low_%0d", i), {7'd0, b_in_ready}, 8'd0);
            check_eq($sformatf("b_done_low_%0d", i), {7'd0, b_done}, 8'd0);
            tick();
            check_eq($sformatf("b_y_off_%0d", i), {4'd0, b_y}, 8'h00);
            check_eq($sformatf("b_done_%0d", i), {7'd0, b_done}, 8'd1);
            check_eq($sformatf("b_ready_hi_%0d", i), {7'd0, b_in_ready}, 8'd1);
        end
        b_in_valid = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
